muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit executing MULT, MULTU, DIV and DIVU for the single-cycle/multi-cycle MIPS datapath. Takes operands from the register file read ports (busA/busB) and produces the 64-bit result that is written into the HI and LO registers. Exposes a start/busy/done handshake so the controller can stall dependent MFHI/MFLO instructions. Sits directly upstream of reg_HI and reg_LO; hi/lo/hi_wr/lo_wr connect to their din/wr ports.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_signfix.sv | 11 +
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit shared definitions
// op codes, FSM states, default width
package muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  function automatic logic op_signed(op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_div(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit request/result bundle
// master = controller, slave = unit
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             hi_wr;
  logic             lo_wr;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo,
    input  hi_wr, lo_wr
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo,
    output hi_wr, lo_wr
  );
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_unit conditional negate
// two's-complement of din when neg is set
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  assign dout = neg ? (~din + W'(1)) : din;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU
// one bit per cycle, result to HI/LO
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave io
);
  localparam int CW = $clog2(WIDTH);

  state_e           state, state_n;
  logic [CW-1:0]    cnt;
  op_e              op_q;
  logic             sa, sb, bz;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] acc_hi_n, acc_lo_n;
  logic [WIDTH:0]   sum, rem_sh, diff;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0] quo_f, rem_f;
  logic             accept, last;

  assign accept = io.start && (state != S_RUN);
  assign last   = (state == S_RUN)
               && (cnt == CW'(WIDTH - 1));

  muldiv_signfix #(.W(WIDTH)) u_abs_a (
    .neg  (op_signed(io.op) & io.a[WIDTH-1]),
    .din  (io.a),
    .dout (abs_a)
  );

  muldiv_signfix #(.W(WIDTH)) u_abs_b (
    .neg  (op_signed(io.op) & io.b[WIDTH-1]),
    .din  (io.b),
    .dout (abs_b)
  );

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .neg  ((op_q == OP_MULT) & (sa ^ sb)),
    .din  ({acc_hi_n, acc_lo_n}),
    .dout (prod_f)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .neg  ((op_q == OP_DIV) & (sa ^ sb)),
    .din  (acc_lo_n),
    .dout (quo_f)
  );

  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .neg  ((op_q == OP_DIV) & sa),
    .din  (acc_hi_n),
    .dout (rem_f)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next state: RUN for WIDTH cycles, FIN one cycle
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (io.start) state_n = S_RUN;
      S_RUN:  if (last)     state_n = S_FIN;
      S_FIN:  state_n = io.start ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // one shift-add or restoring-divide step
  always_comb begin
    acc_hi_n = acc_hi;
    acc_lo_n = acc_lo;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    if (op_div(op_q)) begin
      rem_sh = {acc_hi, acc_lo[WIDTH-1]};
      diff   = rem_sh - {1'b0, y_q};
      if (!diff[WIDTH]) begin
        acc_hi_n = diff[WIDTH-1:0];
        acc_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_n = rem_sh[WIDTH-1:0];
        acc_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, acc_hi}
          + (acc_lo[0] ? {1'b0, x_q} : '0);
      acc_hi_n = sum[WIDTH:1];
      acc_lo_n = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // operand capture, iteration, result load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= OP_MULT;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_q   <= io.op;
      sa     <= op_signed(io.op) & io.a[WIDTH-1];
      sb     <= op_signed(io.op) & io.b[WIDTH-1];
      bz     <= (io.b == '0);
      x_q    <= abs_a;
      y_q    <= abs_b;
      acc_hi <= '0;
      acc_lo <= op_div(io.op) ? abs_a : abs_b;
    end else if (state == S_RUN) begin
      cnt    <= cnt + CW'(1);
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      if (last) begin
        unique case (1'b1)
          op_div(op_q): begin
            hi_q <= rem_f;
            lo_q <= bz ? '1 : quo_f;
          end
          default: begin
            hi_q <= prod_f[2*WIDTH-1:WIDTH];
            lo_q <= prod_f[WIDTH-1:0];
          end
        endcase
      end
    end
  end

  assign io.busy  = (state == S_RUN);
  assign io.done  = (state == S_FIN);
  assign io.hi_wr = io.done;
  assign io.lo_wr = io.done;
  assign io.hi    = hi_q;
  assign io.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// muldiv_unit bench
// directed vectors, queued expectations
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_unit_if io ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (io.done || io.hi_wr || io.lo_wr)) begin
      n_done++;
      if (sbq.size() == 0) begin
        chk("unexpected_write",
            32'({io.done, io.hi_wr, io.lo_wr}), 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_hi"}, io.hi, e.hi);
        chk({e.name, "_lo"}, io.lo, e.lo);
        chk({e.name, "_cycle"}, cyc, e.at);
        chk({e.name, "_done"}, 32'(io.done), 1);
        chk({e.name, "_hi_wr"}, 32'(io.hi_wr), 1);
        chk({e.name, "_lo_wr"}, 32'(io.lo_wr), 1);
        chk({e.name, "_busy"}, 32'(io.busy), 0);
      end
    end
  end

  task automatic issue(op_e op,
                       logic [31:0] a,
                       logic [31:0] b,
                       logic [31:0] eh,
                       logic [31:0] el,
                       string nm);
    @(negedge clk);
    io.start = 1'b1;
    io.op    = op;
    io.a     = a;
    io.b     = b;
    sbq.push_back('{hi: eh, lo: el,
                    at: cyc + 33, name: nm});
    @(negedge clk);
    io.start = 1'b0;
    io.a     = '0;
    io.b     = '0;
    chk({nm, "_busy_start"}, 32'(io.busy), 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || io.busy || io.done)
           && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (k >= 80) chk("drain_timeout", k, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int k;
    io.start = 1'b0;
    io.op    = OP_MULT;
    io.a     = '0;
    io.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(io.busy), 0);
    chk("rst_done", 32'(io.done), 0);
    chk("rst_hi_wr", 32'(io.hi_wr), 0);
    chk("rst_lo_wr", 32'(io.lo_wr), 0);
    chk("rst_hi", io.hi, 0);
    chk("rst_lo", io.lo, 0);
    rst = 1'b0;

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, "multu_max");
    drain();
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7,
          32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
    drain();
    issue(OP_MULT, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h00000000, "mult_min");
    drain();
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    drain();
    issue(OP_DIVU, 32'd7, 32'd2,
          32'd1, 32'd3, "divu_7_2");
    drain();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000, "div_ovf");
    drain();
    issue(OP_DIVU, 32'd5, 32'd0,
          32'd5, 32'hFFFFFFFF, "divu_by0");
    drain();
    issue(OP_DIV, 32'hFFFFFFF8, 32'd0,
          32'hFFFFFFF8, 32'hFFFFFFFF, "div_by0");
    drain();

    issue(OP_MULTU, 32'd6, 32'd7,
          32'd0, 32'd42, "ignored_start");
    repeat (4) @(negedge clk);
    io.start = 1'b1;
    io.op    = OP_DIVU;
    io.a     = 32'd100;
    io.b     = 32'd3;
    @(negedge clk);
    io.start = 1'b0;
    io.a     = '0;
    io.b     = '0;
    drain();

    @(negedge clk);
    io.start = 1'b1;
    io.op    = OP_MULTU;
    io.a     = 32'd3;
    io.b     = 32'd3;
    @(negedge clk);
    io.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_run_busy", 32'(io.busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(io.busy), 0);
    chk("arst_done", 32'(io.done), 0);
    chk("arst_hi", io.hi, 0);
    chk("arst_lo", io.lo, 0);
    snap = n_done;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_wr_after_rst", n_done, snap);

    issue(OP_MULTU, 32'd2, 32'd3,
          32'd0, 32'd6, "b2b_mul");
    k = 0;
    while (!io.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("b2b_done_timeout", k, 0);
    io.start = 1'b1;
    io.op    = OP_DIVU;
    io.a     = 32'd9;
    io.b     = 32'd4;
    sbq.push_back('{hi: 32'd1, lo: 32'd2,
                    at: cyc + 33, name: "b2b_div"});
    @(negedge clk);
    io.start = 1'b0;
    io.a     = '0;
    io.b     = '0;
    repeat (10) @(negedge clk);
    chk("b2b_hold_lo", io.lo, 32'd6);
    chk("b2b_hold_hi", io.hi, 32'd0);
    chk("b2b_busy", 32'(io.busy), 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
